// File: rtl/sddt_rdata_packetizer.sv
// Groups single-beat read results from the read-data FIFO into DMA C2H packets.
// tlast closes a packet on PKT_BEATS beats, an idle timeout, or a host flush.
module sddt_rdata_packetizer #(
  parameter int unsigned DATA_WIDTH     = 512,
  parameter int unsigned PKT_BEATS      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                    axi_aclk,
  input  logic                    axi_aresetn,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  output logic [DATA_WIDTH-1:0]   m_axis_c2h_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_c2h_tkeep,
  output logic                    m_axis_c2h_tlast,
  output logic                    m_axis_c2h_tvalid,
  input  logic                    m_axis_c2h_tready,
  input  logic                    flush,
  output logic [CNT_WIDTH-1:0]    beat_count,
  output logic [CNT_WIDTH-1:0]    pkt_count
);

  localparam int unsigned KEEP_W   = DATA_WIDTH / 8;
  localparam int unsigned IDX_W    = (PKT_BEATS > 1) ? $clog2(PKT_BEATS) : 1;
  localparam int unsigned IC_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned LAST_IDX = (PKT_BEATS > 0) ? PKT_BEATS - 1 : 0;
  localparam int unsigned TO_MAX   = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [IDX_W-1:0] LAST_IDX_V = IDX_W'(LAST_IDX);
  localparam logic [IC_W-1:0]  TO_MAX_V   = IC_W'(TO_MAX);
  localparam bit               TO_EN      = (TIMEOUT_CYCLES != 0);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HELD = 1'b1
  } state_e;

  state_e                r_state;
  state_e                w_state_nxt;
  logic                  r_rdy_en;
  logic [DATA_WIDTH-1:0] r_hold_data;
  logic [IDX_W-1:0]      r_hold_idx;
  logic [IC_W-1:0]       r_idle_cnt;
  logic                  r_flush_pend;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_out_last;
  logic [KEEP_W-1:0]     r_out_keep;
  logic [CNT_WIDTH-1:0]  r_beat_cnt;
  logic [CNT_WIDTH-1:0]  r_pkt_cnt;

  logic                  w_hold_valid;
  logic                  w_out_free;
  logic                  w_accept;
  logic                  w_idx_last;
  logic                  w_timeout;
  logic                  w_move;
  logic                  w_tlast;
  logic                  w_load;
  logic [IDX_W-1:0]      w_hold_idx_nxt;
  logic [IC_W-1:0]       w_idle_cnt_nxt;
  logic                  w_flush_pend_nxt;
  logic                  w_out_hs;

  // Ready is gated off until the first edge after reset release.
  assign w_hold_valid  = (r_state == ST_HELD);
  assign w_out_free    = ~r_out_valid | m_axis_c2h_tready;
  assign s_axis_tready = r_rdy_en & (~w_hold_valid | w_out_free);
  assign w_accept      = s_axis_tvalid & s_axis_tready;
  assign w_idx_last    = (r_hold_idx == LAST_IDX_V);
  assign w_timeout     = TO_EN & (r_idle_cnt == TO_MAX_V);
  assign w_out_hs      = r_out_valid & m_axis_c2h_tready;

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Hold FSM: decides when the held beat moves out and whether it closes the packet.
  always_comb begin
    w_state_nxt      = r_state;
    w_move           = 1'b0;
    w_tlast          = 1'b0;
    w_load           = 1'b0;
    w_hold_idx_nxt   = r_hold_idx;
    w_idle_cnt_nxt   = r_idle_cnt;
    w_flush_pend_nxt = r_flush_pend;
    case (r_state)
      ST_IDLE: begin
        // No packet is ever open in IDLE, so a new beat always starts at index 0.
        w_idle_cnt_nxt   = '0;
        w_flush_pend_nxt = 1'b0;
        if (w_accept) begin
          w_load         = 1'b1;
          w_hold_idx_nxt = '0;
          w_state_nxt    = ST_HELD;
        end
      end
      ST_HELD: begin
        if (w_out_free && (w_accept || w_idx_last || w_timeout || flush || r_flush_pend)) begin
          w_move           = 1'b1;
          w_tlast          = w_idx_last | ~w_accept;
          w_flush_pend_nxt = 1'b0;
          w_idle_cnt_nxt   = '0;
          if (w_accept) begin
            w_load         = 1'b1;
            w_hold_idx_nxt = w_tlast ? '0 : r_hold_idx + IDX_W'(1);
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_flush_pend_nxt = r_flush_pend | flush;
          if (r_idle_cnt != TO_MAX_V) begin
            w_idle_cnt_nxt = r_idle_cnt + IC_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Hold register and FSM side state.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      r_rdy_en     <= 1'b0;
      r_hold_data  <= '0;
      r_hold_idx   <= '0;
      r_idle_cnt   <= '0;
      r_flush_pend <= 1'b0;
    end else begin
      r_rdy_en     <= 1'b1;
      r_idle_cnt   <= w_idle_cnt_nxt;
      r_flush_pend <= w_flush_pend_nxt;
      if (w_load) begin
        r_hold_data <= s_axis_tdata;
        r_hold_idx  <= w_hold_idx_nxt;
      end
    end
  end

  // Output register stays stable while the DMA stalls.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_keep  <= '0;
    end else if (w_move) begin
      r_out_valid <= 1'b1;
      r_out_data  <= r_hold_data;
      r_out_last  <= w_tlast;
      r_out_keep  <= '1;
    end else if (m_axis_c2h_tready) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_keep  <= '0;
    end
  end

  // Status counters, wrapping naturally at 2^CNT_WIDTH.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      r_beat_cnt <= '0;
      r_pkt_cnt  <= '0;
    end else if (w_out_hs) begin
      r_beat_cnt <= r_beat_cnt + CNT_WIDTH'(1);
      if (r_out_last) begin
        r_pkt_cnt <= r_pkt_cnt + CNT_WIDTH'(1);
      end
    end
  end

  assign m_axis_c2h_tdata  = r_out_data;
  assign m_axis_c2h_tkeep  = r_out_keep;
  assign m_axis_c2h_tlast  = r_out_last;
  assign m_axis_c2h_tvalid = r_out_valid;
  assign beat_count        = r_beat_cnt;
  assign pkt_count         = r_pkt_cnt;

endmodule

// File: tb/tb_sddt_rdata_packetizer.sv
// Bench for sddt_rdata_packetizer: instance 0 (PKT_BEATS=4, TIMEOUT=16), instance 1 (PKT_BEATS=1, no timeout).
// A stream-level model predicts each cycle's outputs; directed checks pin the model's timing.
module tb_sddt_rdata_packetizer;

  localparam int unsigned DW = 64;
  localparam int unsigned KW = DW / 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [DW-1:0] s_tdata0 = '0, s_tdata1 = '0;
  logic          s_tvalid0 = 1'b0, s_tvalid1 = 1'b0;
  logic          flush0 = 1'b0, flush1 = 1'b0;
  logic          tr0 = 1'b1, tr1 = 1'b1;
  logic          tr0_req = 1'b1;
  logic          tog_en = 1'b0;

  logic          s_tready0, s_tready1;
  logic [DW-1:0] o_tdata0, o_tdata1;
  logic [KW-1:0] o_tkeep0, o_tkeep1;
  logic          o_tlast0, o_tlast1, o_tvalid0, o_tvalid1;
  logic [31:0]   bc0, bc1, pc0, pc1;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  sddt_rdata_packetizer #(.DATA_WIDTH(DW), .PKT_BEATS(4), .TIMEOUT_CYCLES(16), .CNT_WIDTH(32)) u_dut0 (
    .axi_aclk(clk), .axi_aresetn(rst_n),
    .s_axis_tdata(s_tdata0), .s_axis_tvalid(s_tvalid0), .s_axis_tready(s_tready0),
    .m_axis_c2h_tdata(o_tdata0), .m_axis_c2h_tkeep(o_tkeep0), .m_axis_c2h_tlast(o_tlast0),
    .m_axis_c2h_tvalid(o_tvalid0), .m_axis_c2h_tready(tr0),
    .flush(flush0), .beat_count(bc0), .pkt_count(pc0)
  );

  sddt_rdata_packetizer #(.DATA_WIDTH(DW), .PKT_BEATS(1), .TIMEOUT_CYCLES(0), .CNT_WIDTH(32)) u_dut1 (
    .axi_aclk(clk), .axi_aresetn(rst_n),
    .s_axis_tdata(s_tdata1), .s_axis_tvalid(s_tvalid1), .s_axis_tready(s_tready1),
    .m_axis_c2h_tdata(o_tdata1), .m_axis_c2h_tkeep(o_tkeep1), .m_axis_c2h_tlast(o_tlast1),
    .m_axis_c2h_tvalid(o_tvalid1), .m_axis_c2h_tready(tr1),
    .flush(flush1), .beat_count(bc1), .pkt_count(pc1)
  );

  always #5 clk = ~clk;

  // Sole writer of tr0: either a 1010... pattern or the level the stimulus asks for.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      tr0 = tog_en ? ~tr0 : tr0_req;
    end
  end

  function automatic logic [DW-1:0] beat_data(input int k, input int unsigned n);
    return 64'hC0DE_0000_0000_0000 | (64'(k) << 40) | 64'(n);
  endfunction

  task automatic chk(input int k, input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %h expected %h", nm, k, act, exp);
    end
  endtask

  // Model state per instance: pending beat, expected output slot, counters, history.
  bit             m_rdy[2], m_pv[2], m_fp[2], m_sv[2], m_sl[2];
  logic [DW-1:0]  m_pd[2], m_sd[2];
  int unsigned    m_ppos[2], m_npos[2], m_age[2], m_eb[2], m_ep[2], m_acc[2], m_out[2];
  logic [31:0]    m_mask[2];
  time            t_acc[2], t_tl[2];

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_acc[k] = 0; t_acc[k] = 0; t_tl[k] = 0;
    end
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int k = 0; k < 2; k++) begin
          m_rdy[k] = 0; m_pv[k] = 0; m_fp[k] = 0; m_sv[k] = 0; m_sl[k] = 0;
          m_pd[k] = '0; m_sd[k] = '0; m_ppos[k] = 0; m_npos[k] = 0; m_age[k] = 0;
          m_eb[k] = 0; m_ep[k] = 0; m_mask[k] = '0; m_out[k] = m_acc[k];
        end
      end else begin
        for (int k = 0; k < 2; k++) begin
          int unsigned p, to;
          logic iv, ifl, itr, ordy, ov, ol;
          logic [DW-1:0] id, od;
          logic [KW-1:0] okp;
          logic [31:0] obc, opc;
          bit ofree, erdy, acc, hs, mv, lst;
          if (k == 0) begin
            p = 4; to = 16; iv = s_tvalid0; id = s_tdata0; ifl = flush0; itr = tr0;
            ordy = s_tready0; ov = o_tvalid0; od = o_tdata0; ol = o_tlast0; okp = o_tkeep0;
            obc = bc0; opc = pc0;
          end else begin
            p = 1; to = 0; iv = s_tvalid1; id = s_tdata1; ifl = flush1; itr = tr1;
            ordy = s_tready1; ov = o_tvalid1; od = o_tdata1; ol = o_tlast1; okp = o_tkeep1;
            obc = bc1; opc = pc1;
          end
          ofree = !m_sv[k] || itr;
          erdy  = m_rdy[k] && (!m_pv[k] || ofree);
          chk(k, "s_tready", 64'(ordy), 64'(erdy));
          chk(k, "tvalid", 64'(ov), 64'(m_sv[k]));
          chk(k, "tkeep", 64'(okp), m_sv[k] ? 64'hFF : 64'h0);
          if (m_sv[k]) begin
            chk(k, "tdata", od, m_sd[k]);
            chk(k, "tlast", 64'(ol), 64'(m_sl[k]));
          end
          chk(k, "beat_count", 64'(obc), 64'(m_eb[k]));
          chk(k, "pkt_count", 64'(opc), 64'(m_ep[k]));
          acc = iv && erdy;
          hs  = m_sv[k] && itr;
          if (hs) begin
            chk(k, "order", od, beat_data(k, m_out[k]));
            m_out[k]++;
            if (m_eb[k] < 32) m_mask[k][m_eb[k]] = m_sl[k];
            if (m_sl[k]) begin
              m_ep[k]++;
              t_tl[k] = $time;
            end
            m_eb[k]++;
            m_sv[k] = 0;
          end
          // A held beat leaves when the output can take it and something decides its fate.
          mv  = m_pv[k] && ofree && (acc || (m_ppos[k] == p - 1) ||
                (to != 0 && m_age[k] >= to - 1) || ifl || m_fp[k]);
          lst = (m_ppos[k] == p - 1) || !acc;
          if (mv) begin
            m_sv[k] = 1; m_sd[k] = m_pd[k]; m_sl[k] = lst;
            m_npos[k] = lst ? 0 : m_ppos[k] + 1;
            m_fp[k] = 0; m_pv[k] = 0;
          end else if (m_pv[k]) begin
            m_fp[k] = m_fp[k] || ifl;
            m_age[k]++;
          end
          if (acc) begin
            m_pv[k] = 1; m_pd[k] = id; m_ppos[k] = m_npos[k]; m_age[k] = 0;
            t_acc[k] = $time;
            m_acc[k]++;
          end
          m_rdy[k] = 1;
        end
      end
    end
  end

  int unsigned sent_n[2] = '{0, 0};

  task automatic send(input int k);
    bit got;
    logic [DW-1:0] d;
    d = beat_data(k, sent_n[k]);
    if (k == 0) begin s_tvalid0 = 1'b1; s_tdata0 = d; end
    else        begin s_tvalid1 = 1'b1; s_tdata1 = d; end
    got = 0;
    for (int w = 0; w < 50 && !got; w++) begin
      @(posedge clk);
      got = (k == 0) ? (s_tready0 === 1'b1) : (s_tready1 === 1'b1);
    end
    n_vec++;
    if (!got) begin
      n_err++;
      $display("FAIL send_accept[%0d]: got no accept expected accept within 50 cycles", k);
    end else begin
      sent_n[k]++;
    end
    @(negedge clk);
    if (k == 0) s_tvalid0 = 1'b0;
    else        s_tvalid1 = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    time tf;
    idle(3);
    chk(0, "rst_s_tready", 64'(s_tready0), 64'd0);
    chk(0, "rst_tvalid", 64'(o_tvalid0), 64'd0);
    chk(0, "rst_beat_count", 64'(bc0), 64'd0);
    rst_n = 1'b1;
    idle(1);
    chk(0, "ready_after_release", 64'(s_tready0), 64'd1);

    // Full packets back to back: tlast on beats 4 and 8.
    for (int i = 0; i < 8; i++) send(0);
    idle(6);
    chk(0, "t1_lastmask", 64'(m_mask[0]), 64'h88);
    chk(0, "t1_pkt_count", 64'(pc0), 64'd2);
    chk(0, "t1_beat_count", 64'(bc0), 64'd8);

    // Partial packet closed by the idle timeout, 17 cycles after the last accept edge.
    for (int i = 0; i < 3; i++) send(0);
    idle(25);
    chk(0, "t2_timeout_delay", 64'(t_tl[0] - t_acc[0]), 64'd170);
    chk(0, "t2_pkt_count", 64'(pc0), 64'd3);
    chk(0, "t2_beat_count", 64'(bc0), 64'd11);

    // Flush closes the open packet; a flush in IDLE does nothing.
    for (int i = 0; i < 2; i++) send(0);
    idle(2);
    flush0 = 1'b1;
    @(posedge clk);
    tf = $time;
    @(negedge clk);
    flush0 = 1'b0;
    idle(4);
    chk(0, "t3_flush_delay", 64'(t_tl[0]), 64'(tf + 10));
    chk(0, "t3_pkt_count", 64'(pc0), 64'd4);
    flush0 = 1'b1;
    @(negedge clk);
    flush0 = 1'b0;
    idle(5);
    chk(0, "t3_idle_flush_beats", 64'(bc0), 64'd13);
    chk(0, "t3_idle_flush_pkts", 64'(pc0), 64'd4);

    // Backpressure 1010...: stream integrity and stability via the per-cycle model.
    tog_en = 1'b1;
    for (int i = 0; i < 20; i++) send(0);
    tog_en = 1'b0;
    tr0_req = 1'b1;
    idle(8);
    chk(0, "t4_beat_count", 64'(bc0), 64'd33);
    chk(0, "t4_pkt_count", 64'(pc0), 64'd9);

    // Single-beat packets: T+2 latency and tlast on every beat.
    send(1);
    idle(4);
    chk(1, "t5_latency", 64'(t_tl[1] - t_acc[1]), 64'd20);
    for (int i = 0; i < 5; i++) send(1);
    idle(4);
    chk(1, "t5_lastmask", 64'(m_mask[1]), 64'h3F);
    chk(1, "t5_pkt_count", 64'(pc1), 64'd6);
    chk(1, "t5_beat_count", 64'(bc1), 64'd6);

    // Reset with hold and output both full.
    tr0_req = 1'b0;
    send(0);
    send(0);
    idle(1);
    chk(0, "t6_blocked_ready", 64'(s_tready0), 64'd0);
    chk(0, "t6_blocked_valid", 64'(o_tvalid0), 64'd1);
    rst_n = 1'b0;
    #1;
    chk(0, "t6_rst_tvalid", 64'(o_tvalid0), 64'd0);
    chk(0, "t6_rst_tdata", o_tdata0, 64'd0);
    chk(0, "t6_rst_tlast", 64'(o_tlast0), 64'd0);
    chk(0, "t6_rst_tkeep", 64'(o_tkeep0), 64'd0);
    chk(0, "t6_rst_s_tready", 64'(s_tready0), 64'd0);
    chk(0, "t6_rst_beat_count", 64'(bc0), 64'd0);
    chk(0, "t6_rst_pkt_count", 64'(pc0), 64'd0);
    idle(2);
    rst_n = 1'b1;
    tr0_req = 1'b1;
    idle(1);
    for (int i = 0; i < 5; i++) send(0);
    idle(22);
    chk(0, "t6_lastmask", 64'(m_mask[0]), 64'h18);
    chk(0, "t6_pkt_count", 64'(pc0), 64'd2);
    chk(0, "t6_beat_count", 64'(bc0), 64'd5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
